// File: rtl/sprite_line_engine.sv
// sprite_line_engine: evaluates every object for the next row, renders the hits into
// a back line buffer, and streams the front buffer to the pixel mux.
module sprite_line_engine #(
    parameter int unsigned NUM_OBJECTS     = 64,
    parameter int unsigned MAX_PER_LINE    = 16,
    parameter int unsigned LINE_WIDTH      = 256,
    parameter int unsigned VRAM_ADDR_WIDTH = 12
) (
    input  logic                       gpu_clk,
    input  logic                       rst,
    input  logic [8:0]                 current_x,
    input  logic                       line_start,
    input  logic [8:0]                 next_y,
    input  logic [7:0]                 data_in,
    input  logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    input  logic                       write_enable,
    input  logic                       SELECT_pmf,
    input  logic                       SELECT_obm,
    output logic [1:0]                 r,
    output logic [1:0]                 g,
    output logic [1:0]                 b,
    output logic                       valid,
    output logic                       busy,
    output logic                       overflow,
    output logic                       late
);

    localparam int unsigned OBJ_W = $clog2(NUM_OBJECTS);
    localparam int unsigned HIT_W = $clog2(MAX_PER_LINE + 1);
    localparam int unsigned HIT_N = 2 ** HIT_W;
    localparam int unsigned LB_W  = $clog2(LINE_WIDTH);
    localparam logic [9:0]  LW10  = 10'(LINE_WIDTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAW} state_t;

    state_t            state;
    logic [OBJ_W-1:0]  obj;
    logic [HIT_W-1:0]  hit_cnt;
    logic              exceeded;
    logic [8:0]        cur_y;
    logic              fsel;
    logic              bsel;
    logic [OBJ_W-1:0]  hit_list [HIT_N];

    logic [7:0]        obm [256];
    logic [7:0]        pmf [512];

    // Entry = {colour[2:0], pix[1:0]}; opaque bits kept apart so a buffer clears at once.
    logic [LINE_WIDTH-1:0] opq [2];
    logic [4:0]            ent [2][LINE_WIDTH];

    logic [7:0]        scan_y;
    logic [8:0]        scan_diff;
    logic              scan_hit;
    logic              room;

    logic [HIT_W-1:0]  top_idx;
    logic [OBJ_W-1:0]  d_obj;
    logic [7:0]        d_x;
    logic [7:0]        d_y;
    logic [7:0]        d_attr;
    logic [7:0]        d_col;
    logic [2:0]        d_row;
    logic [15:0]       d_pat;
    logic [1:0]        d_pix [8];
    logic [9:0]        d_sum [8];
    logic [LB_W-1:0]   d_pos [8];
    logic [7:0]        d_we;

    logic [LB_W-1:0]   rd_idx;
    logic [4:0]        rd_ent;

    logic              unused_bits;

    assign bsel        = ~fsel;
    assign unused_bits = ^{d_attr[7], d_col[7:3], vram_address[VRAM_ADDR_WIDTH-1:9]};

    // VRAM write port: OBM and PMF, not reset.
    always_ff @(posedge gpu_clk) begin
        if (write_enable && SELECT_obm) obm[vram_address[7:0]] <= data_in;
        if (write_enable && SELECT_pmf) pmf[vram_address[8:0]] <= data_in;
    end

    // Scan test: next row falls within the 8 rows starting at the object's y, no wrap.
    always_comb begin
        scan_y    = obm[8'({obj, 2'd1})];
        scan_diff = cur_y - {1'b0, scan_y};
        scan_hit  = (cur_y >= {1'b0, scan_y}) && (scan_diff < 9'd8);
        room      = hit_cnt < HIT_W'(MAX_PER_LINE);
    end

    // Draw datapath: fetch the newest hit's row and map its 8 pixels onto buffer entries.
    always_comb begin
        top_idx = hit_cnt - HIT_W'(1);
        d_obj   = hit_list[top_idx];
        d_x     = obm[8'({d_obj, 2'd0})];
        d_y     = obm[8'({d_obj, 2'd1})];
        d_attr  = obm[8'({d_obj, 2'd2})];
        d_col   = obm[8'({d_obj, 2'd3})];
        d_row   = 3'(cur_y - {1'b0, d_y});
        if (d_attr[5]) d_row = ~d_row;
        d_pat   = {pmf[{d_attr[4:0], d_row, 1'b0}], pmf[{d_attr[4:0], d_row, 1'b1}]};
        for (int i = 0; i < 8; i++) begin
            d_pix[i] = d_attr[6] ? d_pat[2*i +: 2] : d_pat[2*(7-i) +: 2];
            d_sum[i] = {2'b00, d_x} + 10'(i);
            d_pos[i] = d_sum[i][LB_W-1:0];
            d_we[i]  = (d_pix[i] != 2'b00) && (d_sum[i] < LW10);
        end
    end

    // Evaluation FSM: line_start from any state restarts the scan on the swapped buffers.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            obj      <= '0;
            hit_cnt  <= '0;
            exceeded <= 1'b0;
            cur_y    <= '0;
            fsel     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            late     <= 1'b0;
        end else if (line_start) begin
            late     <= (state != IDLE);
            overflow <= exceeded;
            fsel     <= ~fsel;
            cur_y    <= next_y;
            hit_cnt  <= '0;
            exceeded <= 1'b0;
            obj      <= '0;
            state    <= SCAN;
            busy     <= 1'b1;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_hit) begin
                        if (room) hit_cnt <= hit_cnt + HIT_W'(1);
                        else      exceeded <= 1'b1;
                    end
                    if (obj == OBJ_W'(NUM_OBJECTS - 1)) begin
                        if (hit_cnt != '0 || scan_hit) begin
                            state <= DRAW;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        obj <= obj + OBJ_W'(1);
                    end
                end
                DRAW: begin
                    hit_cnt <= top_idx;
                    if (hit_cnt == HIT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hit list capture in scan order.
    always_ff @(posedge gpu_clk) begin
        if (!line_start && state == SCAN && scan_hit && room) hit_list[hit_cnt] <= obj;
    end

    // Opaque flags: whole-buffer clear of the new back buffer on line_start, set by draws.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            opq[0] <= '0;
            opq[1] <= '0;
        end else if (line_start) begin
            opq[fsel] <= '0;
        end else if (state == DRAW) begin
            for (int i = 0; i < 8; i++) begin
                if (d_we[i]) opq[bsel][d_pos[i]] <= 1'b1;
            end
        end
    end

    // Colour/pixel payload of the back buffer; lower indices are drawn later and win.
    always_ff @(posedge gpu_clk) begin
        if (!line_start && state == DRAW) begin
            for (int i = 0; i < 8; i++) begin
                if (d_we[i]) ent[bsel][d_pos[i]] <= {d_col[2:0], d_pix[i]};
            end
        end
    end

    assign rd_idx = current_x[LB_W-1:0];
    assign rd_ent = ent[fsel][rd_idx];

    // Registered front-buffer read toward the pixel mux.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            r     <= 2'b00;
            g     <= 2'b00;
            b     <= 2'b00;
        end else if (({1'b0, current_x} < LW10) && opq[fsel][rd_idx]) begin
            valid <= 1'b1;
            r     <= rd_ent[1:0] & {2{rd_ent[4]}};
            g     <= rd_ent[1:0] & {2{rd_ent[3]}};
            b     <= rd_ent[1:0] & {2{rd_ent[2]}};
        end else begin
            valid <= 1'b0;
            r     <= 2'b00;
            g     <= 2'b00;
            b     <= 2'b00;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Testbench for sprite_line_engine: directed and random lines against a pixel-level reference model.
module tb_sprite_line_engine;

    localparam int NOBJ = 64;
    localparam int MAXL = 16;
    localparam int LW   = 256;

    logic        gpu_clk = 1'b0;
    logic        rst;
    logic [8:0]  current_x;
    logic        line_start;
    logic [8:0]  next_y;
    logic [7:0]  data_in;
    logic [11:0] vram_address;
    logic        write_enable;
    logic        SELECT_pmf;
    logic        SELECT_obm;
    logic [1:0]  r, g, b;
    logic        valid, busy, overflow, late;

    sprite_line_engine #(
        .NUM_OBJECTS(NOBJ), .MAX_PER_LINE(MAXL), .LINE_WIDTH(LW), .VRAM_ADDR_WIDTH(12)
    ) dut (
        .gpu_clk(gpu_clk), .rst(rst), .current_x(current_x), .line_start(line_start),
        .next_y(next_y), .data_in(data_in), .vram_address(vram_address),
        .write_enable(write_enable), .SELECT_pmf(SELECT_pmf), .SELECT_obm(SELECT_obm),
        .r(r), .g(g), .b(b), .valid(valid), .busy(busy), .overflow(overflow), .late(late)
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct packed {
        int         x;
        logic       v;
        logic [5:0] rgb;
    } px_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    px_t  exp_q[$];
    logic probe   = 1'b0;
    logic probe_d = 1'b0;

    // Reference state: memory shadows and front/back line images.
    int m_obm[256];
    int m_pmf[512];
    bit fv[LW], bv[LW];
    int fc[LW], fp[LW], bc[LW], bp[LW];
    bit over_pending = 1'b0;
    bit over_exp     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A line is the union of the first MAXL hitting objects; per pixel the lowest
    // index with an opaque pixel there is the one seen.
    function automatic bit model_eval(input int y);
        int hits[$];
        for (int i = 0; i < LW; i++) begin bv[i] = 0; bc[i] = 0; bp[i] = 0; end
        for (int o = 0; o < NOBJ; o++) begin
            int oy = m_obm[4*o+1];
            if (y >= oy && y - oy < 8) hits.push_back(o);
        end
        for (int k = 0; k < hits.size() && k < MAXL; k++) begin
            int o   = hits[k];
            int ox  = m_obm[4*o];
            int at  = m_obm[4*o+2];
            int row = y - m_obm[4*o+1];
            int pat;
            if ((at & 32) != 0) row = 7 - row;
            pat = m_pmf[(at & 31)*16 + row*2] * 256 + m_pmf[(at & 31)*16 + row*2 + 1];
            for (int i = 0; i < 8; i++) begin
                int colm = ((at & 64) != 0) ? 7 - i : i;
                int p    = (pat >> (14 - 2*colm)) & 3;
                if (p != 0 && ox + i < LW && !bv[ox+i]) begin
                    bv[ox+i] = 1;
                    bc[ox+i] = m_obm[4*o+3] & 7;
                    bp[ox+i] = p;
                end
            end
        end
        return hits.size() > MAXL;
    endfunction

    function automatic px_t expect_px(input int x);
        px_t e;
        e.x = x; e.v = 1'b0; e.rgb = 6'd0;
        if (x < LW && fv[x]) begin
            e.v   = 1'b1;
            e.rgb = {((fc[x] & 4) != 0) ? 2'(fp[x]) : 2'd0,
                     ((fc[x] & 2) != 0) ? 2'(fp[x]) : 2'd0,
                     ((fc[x] & 1) != 0) ? 2'(fp[x]) : 2'd0};
        end
        return e;
    endfunction

    function automatic px_t mk(input int x, input logic v, input logic [5:0] rgb);
        px_t e;
        e.x = x; e.v = v; e.rgb = rgb;
        return e;
    endfunction

    task automatic vwr(input bit to_pmf, input int addr, input int val);
        @(negedge gpu_clk);
        write_enable = 1'b1; SELECT_pmf = to_pmf; SELECT_obm = !to_pmf;
        vram_address = 12'(addr); data_in = 8'(val);
        if (to_pmf) m_pmf[addr] = val & 255; else m_obm[addr] = val & 255;
        @(negedge gpu_clk);
        write_enable = 1'b0; SELECT_pmf = 1'b0; SELECT_obm = 1'b0;
    endtask

    task automatic set_obj(input int o, input int x, input int y, input int at, input int col);
        vwr(0, 4*o, x); vwr(0, 4*o+1, y); vwr(0, 4*o+2, at); vwr(0, 4*o+3, col);
    endtask

    task automatic park_all();
        for (int o = 0; o < NOBJ; o++) vwr(0, 4*o+1, 255);
    endtask

    task automatic pulse_line(input int y);
        @(negedge gpu_clk); line_start = 1'b1; next_y = 9'(y);
        @(negedge gpu_clk); line_start = 1'b0;
        fv = bv; fc = bc; fp = bp;
        over_exp     = over_pending;
        over_pending = model_eval(y);
    endtask

    // Evaluate row y, then present it on the next line (row 300 never hits).
    task automatic run_scene(input string name, input int y);
        pulse_line(y);
        chk({name, " late"}, int'(late), 0);
        chk({name, " overflow prev"}, int'(overflow), int'(over_exp));
        repeat (100) @(negedge gpu_clk);
        pulse_line(300);
        chk({name, " late2"}, int'(late), 0);
        chk({name, " overflow"}, int'(overflow), int'(over_exp));
        repeat (80) @(negedge gpu_clk);
    endtask

    task automatic spot(input px_t e);
        @(negedge gpu_clk); current_x = 9'(e.x); probe = 1'b1; exp_q.push_back(e);
        @(negedge gpu_clk); probe = 1'b0;
        @(negedge gpu_clk);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int x = lo; x <= hi; x++) begin
            @(negedge gpu_clk); current_x = 9'(x); probe = 1'b1; exp_q.push_back(expect_px(x));
        end
        @(negedge gpu_clk); probe = 1'b0;
        repeat (2) @(negedge gpu_clk);
    endtask

    // Monitor: each probed pixel appears one clock later; pop and compare.
    always @(posedge gpu_clk) probe_d <= probe;

    always @(negedge gpu_clk) begin
        if (probe_d) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard underflow", 1, 0);
            end else begin
                px_t e;
                e = exp_q.pop_front();
                chk($sformatf("valid x=%0d", e.x), int'(valid), int'(e.v));
                if (e.v) chk($sformatf("rgb x=%0d", e.x), int'({r, g, b}), int'(e.rgb));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; line_start = 1'b0; next_y = '0; current_x = '0; data_in = '0;
        vram_address = '0; write_enable = 1'b0; SELECT_pmf = 1'b0; SELECT_obm = 1'b0;
        for (int i = 0; i < 256; i++) m_obm[i] = 0;
        for (int i = 0; i < 512; i++) m_pmf[i] = 0;
        for (int i = 0; i < LW; i++) begin fv[i] = 0; bv[i] = 0; fc[i] = 0; fp[i] = 0; bc[i] = 0; bp[i] = 0; end

        // Reset state
        repeat (3) @(negedge gpu_clk);
        chk("reset valid", int'(valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset late", int'(late), 0);
        rst = 1'b0;
        sweep(0, 15);

        // Memory contents are undefined after reset; give everything a known value.
        for (int i = 0; i < 256; i++) vwr(0, i, ((i & 3) == 1) ? 255 : 0);
        for (int i = 0; i < 512; i++) vwr(1, i, 0);

        // Single object, single opaque pixel
        set_obj(0, 10, 20, 1, 4);
        vwr(1, 16, 8'hC0); vwr(1, 17, 8'h00);
        run_scene("single", 20);
        spot(mk(10, 1'b1, 6'b110000));
        spot(mk(11, 1'b0, 6'b000000));
        sweep(0, 30);

        // Priority: lower index wins, transparency lets the next one through
        park_all();
        vwr(1, 32, 8'hC0); vwr(1, 33, 8'h00);
        vwr(1, 48, 8'h00); vwr(1, 49, 8'h00);
        set_obj(0, 50, 0, 2, 1);
        set_obj(1, 50, 0, 2, 2);
        run_scene("prio", 0);
        spot(mk(50, 1'b1, 6'b000011));
        vwr(0, 2, 3);
        run_scene("prio transparent", 0);
        spot(mk(50, 1'b1, 6'b001100));
        sweep(40, 60);

        // Per-line limit and overflow
        park_all();
        vwr(1, 64, 8'hFF); vwr(1, 65, 8'hFF);
        for (int o = 0; o < 20; o++) set_obj(o, o*12, 5, 4, (o % 7) + 1);
        run_scene("limit20", 5);
        chk("overflow after 20 hits", int'(overflow), 1);
        spot(mk(180, 1'b1, expect_px(180).rgb));
        spot(mk(192, 1'b0, 6'b000000));
        sweep(0, 259);
        park_all();
        for (int o = 0; o < 3; o++) set_obj(o, o*20, 5, 4, 7);
        run_scene("limit3", 5);
        chk("overflow after 3 hits", int'(overflow), 0);
        sweep(0, 70);

        // Right edge clipping and no vertical wrap
        park_all();
        vwr(1, 80, 8'hFF); vwr(1, 81, 8'hFF);
        set_obj(0, 252, 40, 5, 7);
        set_obj(1, 100, 250, 5, 7);
        run_scene("edge", 40);
        for (int x = 252; x < 256; x++) spot(mk(x, 1'b1, 6'b111111));
        spot(mk(0, 1'b0, 6'b000000));
        spot(mk(3, 1'b0, 6'b000000));
        sweep(0, 261);
        run_scene("nowrap", 2);
        spot(mk(100, 1'b0, 6'b000000));

        // Flips
        park_all();
        for (int i = 96; i < 110; i++) vwr(1, i, 0);
        vwr(1, 110, 8'h00); vwr(1, 111, 8'h03);
        set_obj(0, 100, 60, 8'h66, 2);
        run_scene("hvflip", 60);
        spot(mk(100, 1'b1, 6'b001100));
        spot(mk(107, 1'b0, 6'b000000));
        vwr(0, 2, 6);
        run_scene("noflip row7", 67);
        spot(mk(107, 1'b1, 6'b001100));
        spot(mk(100, 1'b0, 6'b000000));
        run_scene("noflip row0", 60);
        sweep(95, 112);

        // Random object tables and patterns
        for (int round = 0; round < 5; round++) begin
            int ylo = (round < 3) ? 96 : 60;
            int yhi = (round < 3) ? 104 : 140;
            for (int o = 0; o < NOBJ; o++)
                set_obj(o, int'($urandom_range(0, 255)), int'($urandom_range(ylo, yhi)),
                        int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
            for (int i = 0; i < 512; i++) vwr(1, i, int'($urandom_range(0, 255)));
            run_scene($sformatf("random%0d", round), int'($urandom_range(98, 106)));
            sweep(0, 259);
        end

        // Late evaluation: pulses closer than a full scan
        set_obj(0, 10, 100, 4, 7);
        for (int i = 64; i < 80; i++) vwr(1, i, 8'hFF);
        pulse_line(100);
        chk("late first", int'(late), 0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 28; c++) begin
                @(negedge gpu_clk);
                chk($sformatf("busy during short line %0d", k), int'(busy), 1);
            end
            pulse_line(100);
            chk($sformatf("late %0d", k), int'(late), 1);
        end
        repeat (100) @(negedge gpu_clk);
        pulse_line(300);
        chk("late cleared", int'(late), 0);
        chk("overflow after full line", int'(overflow), int'(over_exp));
        @(negedge gpu_clk); current_x = 9'd10;
        @(negedge gpu_clk);
        chk("busy mid scan", int'(busy), 1);
        chk("valid before reset", int'(valid), 1);
        chk("rgb before reset", int'({r, g, b}), 6'b111111);

        // Asynchronous reset mid-scan
        @(posedge gpu_clk); #2;
        rst = 1'b1;
        #1;
        chk("async reset busy", int'(busy), 0);
        chk("async reset valid", int'(valid), 0);
        @(negedge gpu_clk);
        rst = 1'b0;
        for (int i = 0; i < LW; i++) begin fv[i] = 0; bv[i] = 0; end
        over_pending = 1'b0; over_exp = 1'b0;
        sweep(0, 20);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
